mem_req_queue: RTL and testbench

Request-side front end for `MemoryHierarchy`. It buffers byte-wide load/store requests from a core-side producer in a small FIFO and issues them one at a time on the hierarchy's `u_request`/`u_we`/`u_addr`/`u_din` port. Each completion (`u_ready`) is returned to the producer as a one-cycle response carrying the read data. It sits directly upstream of the hierarchy and decouples the core from the variable 2–15-cycle L1/L2/memory latency.

---
 rtl/mem_req_pkg.sv | 19 +
 rtl/req_fifo.sv | 52 +++++
 rtl/mem_req_queue.sv | 121 ++++++++++++
 tb/tb_mem_req_queue.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared types for the memory request queue front end.
// Request entry bundle and issue FSM state encoding.
package mem_req_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } req_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_t;

endpackage

// File: rtl/req_fifo.sv
// Request FIFO with a combinational head view.
// Occupancy count keeps full and empty unambiguous.
module req_fifo
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  req_entry_t din,
    output req_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    req_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_req_queue.sv
// Buffers byte load/store requests and issues them one at a time.
// Optional statistics counters: define MEM_REQ_QUEUE_STATS_EN.
module mem_req_queue
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_din,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_data,
    output logic              u_request,
    output logic              u_we,
    output logic [ADDR_W-1:0] u_addr,
    output logic [DATA_W-1:0] u_din,
    input  logic              u_ready,
    input  logic [DATA_W-1:0] u_dout,
    output logic [15:0]       stat_reads,
    output logic [15:0]       stat_writes,
    output logic [15:0]       stat_wait
);

    issue_state_t state;
    req_entry_t   head;
    req_entry_t   entry;
    logic         full;
    logic         empty;
    logic         pop;
    logic         done;

    assign req_ready = !full;
    assign entry     = '{we: req_we, addr: req_addr, din: req_din};
    assign pop       = (state == IDLE) && !empty;
    assign done      = (state == ISSUE) && u_ready;

    req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid),
        .pop   (pop),
        .din   (entry),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            u_request <= 1'b0;
            u_we      <= 1'b0;
            u_addr    <= '0;
            u_din     <= '0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        u_we      <= head.we;
                        u_addr    <= head.addr;
                        u_din     <= head.din;
                        u_request <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Dropping to IDLE guarantees a one-cycle request gap.
                    if (done) begin
                        u_request <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_we    <= u_we;
                        rsp_data  <= u_we ? '0 : u_dout;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_REQ_QUEUE_STATS_EN
    logic [15:0] reads_q;
    logic [15:0] writes_q;
    logic [15:0] wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads_q  <= '0;
            writes_q <= '0;
            wait_q   <= '0;
        end else begin
            if (done && !u_we && reads_q != 16'hFFFF)
                reads_q <= reads_q + 16'd1;
            if (done && u_we && writes_q != 16'hFFFF)
                writes_q <= writes_q + 16'd1;
            if (u_request && wait_q != 16'hFFFF)
                wait_q <= wait_q + 16'd1;
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_wait   = wait_q;
`else
    assign stat_reads  = 16'h0000;
    assign stat_writes = 16'h0000;
    assign stat_wait   = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue with a behavioural hierarchy model.
// Statistics checks follow MEM_REQ_QUEUE_STATS_EN.
module tb_mem_req_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [7:0]  req_din = 8'h00;
    logic        rsp_valid;
    logic        rsp_we;
    logic [7:0]  rsp_data;
    logic        u_request;
    logic        u_we;
    logic [7:0]  u_addr;
    logic [7:0]  u_din;
    logic        u_ready;
    logic [7:0]  u_dout;
    logic [15:0] stat_reads;
    logic [15:0] stat_writes;
    logic [15:0] stat_wait;

    always #5 clk = ~clk;

    mem_req_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_din     (req_din),
        .rsp_valid   (rsp_valid),
        .rsp_we      (rsp_we),
        .rsp_data    (rsp_data),
        .u_request   (u_request),
        .u_we        (u_we),
        .u_addr      (u_addr),
        .u_din       (u_din),
        .u_ready     (u_ready),
        .u_dout      (u_dout),
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_wait   (stat_wait)
    );

    // Hierarchy model: memory preloaded with mem[a] = a, fixed latency.
    logic [7:0] mem [256];
    logic       mdl_ready;
    int         lat_cnt;
    int         lat = 9;
    logic       stall = 1'b0;
    logic       spur = 1'b0;

    assign u_ready = mdl_ready | spur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_ready <= 1'b0;
            lat_cnt   <= 0;
            u_dout    <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else begin
            mdl_ready <= 1'b0;
            if (u_request && !mdl_ready && !stall) begin
                if (lat_cnt >= lat - 2) begin
                    mdl_ready <= 1'b1;
                    u_dout    <= mem[u_addr];
                    if (u_we) mem[u_addr] <= u_din;
                    lat_cnt   <= 0;
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end
    end

    typedef struct packed {
        logic       we;
        logic [7:0] data;
    } rsp_t;

    rsp_t        got[$];
    int          runs[$];
    int          gaps[$];
    int          run_len;
    int          gap_len;
    int          hi_total;
    int          hold_err;
    logic        seen;
    logic [16:0] prev_cmd;

    always @(negedge clk) begin
        if (!rst_n) begin
            got.delete();
            runs.delete();
            gaps.delete();
            run_len  = 0;
            gap_len  = 0;
            hi_total = 0;
            seen     = 1'b0;
        end else begin
            if (rsp_valid) got.push_back({rsp_we, rsp_data});
            if (u_request) begin
                hi_total++;
                if (run_len == 0 && seen) gaps.push_back(gap_len);
                if (run_len > 0 && prev_cmd != {u_we, u_addr, u_din})
                    hold_err++;
                run_len++;
                gap_len  = 0;
                seen     = 1'b1;
                prev_cmd = {u_we, u_addr, u_din};
            end else begin
                if (run_len > 0) runs.push_back(run_len);
                run_len = 0;
                gap_len++;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        stall     = 1'b0;
        spur      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic we, input logic [7:0] a,
                        input logic [7:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_din   = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic push_wait(input logic we, input logic [7:0] a,
                             input logic [7:0] d);
        int n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (!req_ready) check("push_wait", {31'b0, req_ready}, 32'd1);
        push(we, a, d);
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("rsp_count", got.size(), n);
    endtask

    task automatic check_rsp(input int idx, input logic we,
                             input logic [7:0] data);
        rsp_t r;
        r = (idx < got.size()) ? got[idx] : 9'h1FF;
        check($sformatf("rsp%0d_we", idx), {31'b0, r.we}, {31'b0, we});
        check($sformatf("rsp%0d_data", idx), {24'b0, r.data}, {24'b0, data});
    endtask

    logic       v_we   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] v_addr [8] = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h05, 8'h05, 8'h05, 8'h7F};
    logic [7:0] v_din  [8] = '{8'h55, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00};
    logic [7:0] v_exp  [8] = '{8'h00, 8'h55, 8'h00, 8'hAA, 8'h05, 8'h00, 8'h3C, 8'h7F};

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        hold_err = 0;

        rst_n = 1'b0;
        tick();
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_u_request", {31'b0, u_request}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_u_cmd", {15'b0, u_we, u_addr, u_din}, 32'd0);
        check("rst_rsp", {23'b0, rsp_we, rsp_data}, 32'd0);
        check("rst_stats", {stat_reads | stat_writes, stat_wait}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Cold read with 9-cycle request hold.
        lat = 9;
        push(1'b0, 8'h00, 8'h00);
        check("issue_at_e", {31'b0, u_request}, 32'd0);
        tick();
        check("issue_at_e1", {31'b0, u_request}, 32'd1);
        wait_rsp(1, 40);
        check("cold_hold", runs.size() > 0 ? runs[0] : -1, 32'd9);
        check_rsp(0, 1'b0, 8'h00);

        // Back-to-back mix.
        do_reset();
        lat = 3;
        push(1'b0, 8'h02, 8'h00);
        push(1'b1, 8'h80, 8'hFF);
        push(1'b1, 8'h03, 8'hFF);
        push(1'b0, 8'hC0, 8'h00);
        push(1'b0, 8'h42, 8'h00);
        wait_rsp(5, 80);
        check_rsp(0, 1'b0, 8'h02);
        check_rsp(1, 1'b1, 8'h00);
        check_rsp(2, 1'b1, 8'h00);
        check_rsp(3, 1'b0, 8'hC0);
        check_rsp(4, 1'b0, 8'h42);
        check("b2b_gaps", gaps.size(), 32'd4);
        foreach (gaps[i]) check($sformatf("b2b_gap%0d", i), gaps[i], 32'd1);
        check("b2b_hi_total", hi_total, 32'd15);
`ifdef MEM_REQ_QUEUE_STATS_EN
        check("stat_reads", {16'b0, stat_reads}, 32'd3);
        check("stat_writes", {16'b0, stat_writes}, 32'd2);
        check("stat_wait", {16'b0, stat_wait}, 32'd15);
`else
        check("stat_off", {stat_reads | stat_writes, stat_wait}, 32'd0);
`endif

        // Full queue with stalled hierarchy.
        do_reset();
        stall = 1'b1;
        lat   = 2;
        acc   = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            check($sformatf("full_ready%0d", i), {31'b0, req_ready},
                  (i < DEPTH + 1) ? 32'd1 : 32'd0);
            if (req_ready) acc++;
            push(1'b0, 8'h20 + 8'(i), 8'h00);
        end
        check("full_accepts", acc, 32'd5);
        check("full_ready_low", {31'b0, req_ready}, 32'd0);
        stall = 1'b0;
        wait_rsp(5, 100);
        repeat (20) tick();
        check("full_no_extra", got.size(), 32'd5);
        for (int i = 0; i < 5; i++) check_rsp(i, 1'b0, 8'h20 + 8'(i));
        check("full_drained", {31'b0, req_ready}, 32'd1);

        // Eight requests through the FIFO, pointers wrap.
        do_reset();
        lat = 2;
        for (int i = 0; i < 8; i++) push_wait(v_we[i], v_addr[i], v_din[i]);
        wait_rsp(8, 200);
        for (int i = 0; i < 8; i++) check_rsp(i, v_we[i], v_exp[i]);

        // Spurious ready while idle.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        tick();
        check("spur_no_rsp", got.size(), 32'd8);
        check("spur_idle", {31'b0, u_request}, 32'd0);

        // Reset while a request is in flight and three are queued.
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, 8'h60 + 8'(i), 8'h99);
        check("mid_issue", {31'b0, u_request}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, u_request}, 32'd0);
        check("mid_rst_cmd", {15'b0, u_we, u_addr, u_din}, 32'd0);
        check("mid_rst_rsp", {31'b0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        tick();
        tick();
        stall = 1'b0;
        rst_n = 1'b1;
        repeat (20) tick();
        check("mid_no_rsp", got.size(), 32'd0);
        check("mid_no_issue", hi_total, 32'd0);

        check("hold_stable", hold_err, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
